pr_rank_sorter: RTL and testbench
=================================

Name: pr_rank_sorter

Overview:
- Downstream stage of pageRank16: captures all N node rank values in one snapshot and sorts them in descending order, with ties ordered by ascending node index.
- Sorting uses odd-even transposition over N clock cycles.
- Emits the ranked list one (value, node index) pair per transfer over a valid/ready stream, highest rank first.
- Provides the "Sort" half of the PageRank-Sort datapath.

Parameters:
- N, 16, number of nodes; even, ≥2.
- WIDTH, 16, bits per rank value; unsigned.
- IDXW, 4, node index width; must satisfy 2^IDXW ≥ N.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (reset==0 at a clk edge resets the block)
- start  input  1  request a new sort; sampled only in IDLE
- nodeVal  input  N*WIDTH  node i value at bits [(i+1)*WIDTH-1 : i*WIDTH]
- busy  output  1  high in SORT and EMIT
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready from consumer
- out_val  output  WIDTH  current ranked value
- out_idx  output  IDXW  node index of out_val
- out_last  output  1  high with the final (N-th) element
- done  output  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, pass counter=0, emit pointer=0.
  - busy, out_valid, out_last, done = 0; out_val, out_idx = 0.
  - Array registers cleared.
  - Reset overrides everything, including mid-SORT and mid-EMIT; any partial stream is abandoned with no done pulse.
- IDLE:
  - start==1 at an edge loads slot i with {nodeVal[i], idx=i} for all i.
  - Pass counter is cleared; state→SORT.
  - start is ignored in all other states.
- SORT, one pass per cycle; pass p = 0..N-1:
  - Even p compares slot pairs (0,1),(2,3),…; odd p compares pairs (1,2),(3,4),…,(N-3,N-2).
  - Pair (a,b), a at the lower slot, swaps when val_a < val_b, or when val_a == val_b and idx_a > idx_b.
  - Comparison is unsigned and full-width; no arithmetic, no overflow.
  - After pass N-1 completes: state→EMIT, emit pointer=0.
- Latency: if start is sampled at edge E0, out_valid is first high after edge E0+N+1, i.e. N+1 cycles of latency.
- EMIT:
  - out_valid=1; out_val/out_idx = slot[emit pointer]; out_last = (pointer==N-1).
  - Outputs stay stable while out_ready==0, with no bubbles inserted.
  - out_valid && out_ready at an edge advances the pointer.
  - Acceptance at pointer N-1 moves state→IDLE, drops out_valid, and asserts done for exactly the following cycle.
  - busy falls in the same cycle that done is high.
- Back-to-back: start sampled in the same cycle done is high is accepted, because the state is IDLE.
- nodeVal may change freely after the load edge; the snapshot is unaffected.
- All outputs are registered; no combinational path from out_ready to out_valid.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 → busy=0, out_valid=0, done=0, out_val=0 throughout.
- pageRank16 pattern: nodes cycle 16'h5555, 16'h8000, 16'hFFFF, 16'h8000 across idx 0..15; start; out_ready=1 → out_valid rises N+1=17 cycles after the start edge.
  - Required stream: FFFF with idx 2,6,10,14; then 8000 with idx 1,3,5,7,9,11,13,15; then 5555 with idx 0,4,8,12.
  - out_last is high only on idx 12; done pulses once on the next cycle.
- Reverse-sorted input: node i = i (ascending) → stream 15,14,…,0 with idx equal to value. This exercises the worst case for N passes.
- Backpressure: toggle out_ready 1,0,0,1 pseudo-randomly → out_val/out_idx hold while stalled; exactly 16 transfers, order identical to the out_ready=1 run.
- Reset mid-operation:
  - Drive reset=0 during SORT pass 5 → next cycle busy=0, out_valid=0, no done pulse.
  - A new start with all-equal values (16'h1234) → stream idx 0..15 in order.
- start ignored while busy: pulse start with different nodeVal during EMIT → current stream unchanged. Re-asserting start on the done cycle starts a new sort with output 17 cycles later.

Source files
------------

// File: rtl/pr_rank_sorter.sv
// Snapshot N rank values, sort descending (ties: ascending node index), stream them out.
// Latency: N+1 cycles from the start edge to the first out_valid; one element per accepted transfer.
// Backpressure: out_ready low holds the current element stable; no bubbles and no combinational ready->valid path.
module pr_rank_sorter #(
    parameter int N     = 16,
    parameter int WIDTH = 16,
    parameter int IDXW  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   nodeVal,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_val,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_last,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, SORT, EMIT} state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    state_t              state_q;
    logic [IDXW-1:0]     pass_q;
    logic [IDXW-1:0]     ptr_q;
    logic [IDXW-1:0]     ptr_nxt;
    logic [WIDTH-1:0]    val_q [N];
    logic [IDXW-1:0]     idx_q [N];
    logic [WIDTH-1:0]    val_d [N];
    logic [IDXW-1:0]     idx_d [N];
    logic                busy_q;
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_val_q;
    logic [IDXW-1:0]     out_idx_q;
    logic                out_last_q;
    logic                done_q;

    assign ptr_nxt = ptr_q + 1'b1;

    // One odd-even transposition pass over the slot array; pass parity picks the pairing.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            val_d[k] = val_q[k];
            idx_d[k] = idx_q[k];
        end
        for (int a = 0; a < N - 1; a++) begin
            if (((a % 2) == int'(pass_q[0])) && ((a + 1) < (N - int'(pass_q[0])))) begin
                // Lower slot must hold the larger value; equal values keep the lower index first.
                if ((val_q[a] < val_q[a+1]) ||
                    ((val_q[a] == val_q[a+1]) && (idx_q[a] > idx_q[a+1]))) begin
                    val_d[a]   = val_q[a+1];
                    idx_d[a]   = idx_q[a+1];
                    val_d[a+1] = val_q[a];
                    idx_d[a+1] = idx_q[a];
                end
            end
        end
    end

    // Control FSM, slot array and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_val_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            for (int k = 0; k < N; k++) begin
                val_q[k] <= '0;
                idx_q[k] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N; k++) begin
                            val_q[k] <= nodeVal[k*WIDTH +: WIDTH];
                            idx_q[k] <= IDXW'(k);
                        end
                        pass_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SORT;
                    end
                end
                SORT: begin
                    for (int k = 0; k < N; k++) begin
                        val_q[k] <= val_d[k];
                        idx_q[k] <= idx_d[k];
                    end
                    if (pass_q == LAST) begin
                        state_q <= EMIT;
                        ptr_q   <= '0;
                    end else begin
                        pass_q <= pass_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (!out_valid_q) begin
                        // First EMIT cycle: present the head of the sorted list.
                        out_valid_q <= 1'b1;
                        out_val_q   <= val_q[ptr_q];
                        out_idx_q   <= idx_q[ptr_q];
                        out_last_q  <= (ptr_q == LAST);
                    end else if (out_ready) begin
                        if (ptr_q == LAST) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            ptr_q      <= ptr_nxt;
                            out_val_q  <= val_q[ptr_nxt];
                            out_idx_q  <= idx_q[ptr_nxt];
                            out_last_q <= (ptr_nxt == LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_val   = out_val_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pr_rank_sorter.sv
// Directed bench for pr_rank_sorter: reset, sort order, latency, backpressure, mid-run reset, restart.
// Latency: n/a.
// Backpressure: out_ready driven from a fixed pseudo-random pattern in the stall test.
module tb_pr_rank_sorter;

    localparam int N = 16;
    localparam int W = 16;
    localparam int I = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [N*W-1:0]   nodeVal;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_val;
    logic [I-1:0]     out_idx;
    logic             out_last;
    logic             done;

    int n_chk  = 0;
    int n_pass = 0;

    // Captured stream and timing from the most recent run_stream call.
    logic [W-1:0] got_val  [32];
    logic [I-1:0] got_idx  [32];
    logic         got_last [32];
    int n_xfer, first_valid, done_cnt, done_cyc, last_xfer_cyc, hold_err;
    bit timeout;
    logic busy_at_done, valid_at_done;

    always #5 clk = ~clk;

    pr_rank_sorter #(.N(N), .WIDTH(W), .IDXW(I)) dut (
        .clk(clk), .reset(reset), .start(start), .nodeVal(nodeVal),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_val(out_val), .out_idx(out_idx), .out_last(out_last), .done(done)
    );

    function automatic logic [W-1:0] pat_val(input int i);
        case (i % 4)
            0:       return 16'h5555;
            2:       return 16'hFFFF;
            default: return 16'h8000;
        endcase
    endfunction

    function automatic logic [N*W-1:0] mk_pat();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = pat_val(i);
        return v;
    endfunction

    function automatic logic [N*W-1:0] mk_asc();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(i);
        return v;
    endfunction

    function automatic logic [N*W-1:0] mk_const(input logic [W-1:0] c);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = c;
        return v;
    endfunction

    // Stimulus/capture driver: issues start now (time = edge+1), then records the stream.
    task automatic run_stream(input logic [N*W-1:0] vals, input bit bp, input bit poke, input bit ret_on_done);
        int cyc, post;
        bit stall_prev, poked, seen_done;
        logic [W-1:0] pv;
        logic [I-1:0] pi;
        logic pl;
        logic [3:0] pat;
        pat = 4'b1001;
        n_xfer = 0; first_valid = -1; done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1;
        hold_err = 0; timeout = 0; busy_at_done = 1'b1; valid_at_done = 1'b1;
        nodeVal = vals;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; post = 0; stall_prev = 0; poked = 0; seen_done = 0;
        pv = '0; pi = '0; pl = 1'b0;
        while (1) begin
            out_ready = bp ? pat[(cyc + cyc / 5) % 4] : 1'b1;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (stall_prev && out_valid && (out_val !== pv || out_idx !== pi || out_last !== pl))
                hold_err++;
            if (done === 1'b1) begin
                done_cnt++;
                if (!seen_done) begin
                    done_cyc = cyc; busy_at_done = busy; valid_at_done = out_valid;
                end
                seen_done = 1;
            end
            if (out_valid && out_ready) begin
                if (n_xfer < 32) begin
                    got_val[n_xfer] = out_val; got_idx[n_xfer] = out_idx; got_last[n_xfer] = out_last;
                end
                n_xfer++;
                last_xfer_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            pv = out_val; pi = out_idx; pl = out_last;
            if (seen_done && ret_on_done) return;
            if (seen_done) post++;
            if (post > 3) break;
            if (cyc >= 300) begin timeout = 1; break; end
            start = 1'b0;
            if (poke && !poked && n_xfer == 5) begin
                start = 1'b1; nodeVal = ~vals; poked = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; out_ready = 1'b1; nodeVal = mk_pat();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({busy, out_valid, done} !== 3'b000 || out_val !== 16'h0) begin
                $display("FAIL reset c%0d: busy=%b valid=%b done=%b val=%h, required 0 0 0 0000",
                         c, busy, out_valid, done, out_val);
            end else n_pass++;
        end
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_pattern();
        int exp_idx [16] = '{2, 6, 10, 14, 1, 3, 5, 7, 9, 11, 13, 15, 0, 4, 8, 12};
        run_stream(mk_pat(), 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (timeout || first_valid != 17) $display("FAIL pat_latency: got %0d (timeout=%0d), required 17", first_valid, timeout);
        else n_pass++;
        n_chk++;
        if (n_xfer != 16) $display("FAIL pat_count: got %0d, required 16", n_xfer);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (got_val[k] !== pat_val(exp_idx[k]) || got_idx[k] !== I'(exp_idx[k]) || got_last[k] !== (k == 15))
                $display("FAIL pat_elem%0d: got %h/%0d last=%b, required %h/%0d last=%b",
                         k, got_val[k], got_idx[k], got_last[k], pat_val(exp_idx[k]), exp_idx[k], (k == 15));
            else n_pass++;
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != last_xfer_cyc + 1 || busy_at_done !== 1'b0 || valid_at_done !== 1'b0)
            $display("FAIL pat_done: cnt=%0d cyc=%0d busy=%b valid=%b, required 1 %0d 0 0",
                     done_cnt, done_cyc, busy_at_done, valid_at_done, last_xfer_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_reverse();
        run_stream(mk_asc(), 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (first_valid != 17 || n_xfer != 16) $display("FAIL rev_lat_count: lat=%0d n=%0d, required 17 16", first_valid, n_xfer);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (got_val[k] !== W'(15 - k) || got_idx[k] !== I'(15 - k))
                $display("FAIL rev_elem%0d: got %0d/%0d, required %0d/%0d", k, got_val[k], got_idx[k], 15 - k, 15 - k);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int exp_idx [16] = '{2, 6, 10, 14, 1, 3, 5, 7, 9, 11, 13, 15, 0, 4, 8, 12};
        run_stream(mk_pat(), 1'b1, 1'b0, 1'b0);
        n_chk++;
        if (timeout || n_xfer != 16) $display("FAIL bp_count: got %0d (timeout=%0d), required 16", n_xfer, timeout);
        else n_pass++;
        n_chk++;
        if (hold_err != 0) $display("FAIL bp_hold: %0d unstable stall cycles, required 0", hold_err);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (got_val[k] !== pat_val(exp_idx[k]) || got_idx[k] !== I'(exp_idx[k]))
                $display("FAIL bp_elem%0d: got %h/%0d, required %h/%0d", k, got_val[k], got_idx[k], pat_val(exp_idx[k]), exp_idx[k]);
            else n_pass++;
        end
        n_chk++;
        if (done_cnt != 1) $display("FAIL bp_done: got %0d pulses, required 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int bad;
        nodeVal = mk_pat(); start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_chk++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL midrst_state: busy=%b valid=%b done=%b, required 0 0 0", busy, out_valid, done);
        else n_pass++;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL midrst_quiet: %0d active cycles, required 0", bad);
        else n_pass++;
        run_stream(mk_const(16'h1234), 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (n_xfer != 16) $display("FAIL eq_count: got %0d, required 16", n_xfer);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (got_val[k] !== 16'h1234 || got_idx[k] !== I'(k))
                $display("FAIL eq_elem%0d: got %h/%0d, required 1234/%0d", k, got_val[k], got_idx[k], k);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        int exp_idx [16] = '{2, 6, 10, 14, 1, 3, 5, 7, 9, 11, 13, 15, 0, 4, 8, 12};
        run_stream(mk_pat(), 1'b0, 1'b1, 1'b0);
        n_chk++;
        if (n_xfer != 16 || done_cnt != 1) $display("FAIL ign_count: n=%0d done=%0d, required 16 1", n_xfer, done_cnt);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_chk++;
            if (got_val[k] !== pat_val(exp_idx[k]) || got_idx[k] !== I'(exp_idx[k]))
                $display("FAIL ign_elem%0d: got %h/%0d, required %h/%0d", k, got_val[k], got_idx[k], pat_val(exp_idx[k]), exp_idx[k]);
            else n_pass++;
        end
        n_chk++;
        if (busy !== 1'b0) $display("FAIL ign_idle: busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_stream(mk_pat(), 1'b0, 1'b0, 1'b1);
        n_chk++;
        if (done_cyc < 0 || n_xfer != 16) $display("FAIL b2b_first: done_cyc=%0d n=%0d, required >=0 16", done_cyc, n_xfer);
        else n_pass++;
        run_stream(mk_asc(), 1'b0, 1'b0, 1'b0);
        n_chk++;
        if (first_valid != 17 || n_xfer != 16) $display("FAIL b2b_lat: lat=%0d n=%0d, required 17 16", first_valid, n_xfer);
        else n_pass++;
        n_chk++;
        if (got_val[0] !== 16'd15 || got_idx[0] !== 4'd15 || got_val[15] !== 16'd0 || got_idx[15] !== 4'd0)
            $display("FAIL b2b_order: head %0d/%0d tail %0d/%0d, required 15/15 0/0",
                     got_val[0], got_idx[0], got_val[15], got_idx[15]);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; out_ready = 1'b1; nodeVal = '0;
        test_reset();
        test_pattern();
        test_reverse();
        test_backpressure();
        test_mid_reset();
        test_start_ignored();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
